// File: rtl/mpy_pkg.sv
// Shared widths and state codes for the multiply/divide cores.
// Holds the 14x16 multiplier sizes alongside the 30/16 divider.
package mpy_pkg;
  localparam int MPY_NA = 14;
  localparam int MPY_NB = 16;

  localparam int NN   = 30;
  localparam int ND   = 16;
  localparam int LGNN = 5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef struct packed {
    logic [NN-1:0] q;
    logic [ND-1:0] r;
    logic          err;
    logic          aux;
  } udiv_res_t;
endpackage

// File: rtl/udiv_30x16_if.sv
// Request/result bundle of the 30x16 divider.
// master: requester drives i_*; slave: divider drives o_*.
interface udiv_30x16_if;
  import mpy_pkg::*;
  logic          i_wr;
  logic [NN-1:0] i_n;
  logic [ND-1:0] i_d;
  logic          i_aux;
  logic          o_busy;
  logic          o_valid;
  logic [NN-1:0] o_q;
  logic [ND-1:0] o_r;
  logic          o_err;
  logic          o_aux;

  modport master (
    output i_wr, i_n, i_d, i_aux,
    input  o_busy, o_valid, o_q, o_r,
    input  o_err, o_aux
  );

  modport slave (
    input  i_wr, i_n, i_d, i_aux,
    output o_busy, o_valid, o_q, o_r,
    output o_err, o_aux
  );
endinterface

// File: rtl/udiv_step.sv
// One restoring-division step: shift in a dividend bit, trial subtract.
// In: i_r partial remainder, i_bit next bit, i_d divisor. Out: o_r, o_q.
module udiv_step
  import mpy_pkg::*;
(
  input  logic [ND-1:0] i_r,
  input  logic          i_bit,
  input  logic [ND-1:0] i_d,
  output logic [ND:0]   o_r,
  output logic          o_q
);
  logic [ND:0]   w_t;
  logic [ND+1:0] w_diff;

  assign w_t    = {i_r, i_bit};
  // Top bit of the widened difference is the borrow-out.
  assign w_diff = {1'b0, w_t} - {2'b00, i_d};
  assign o_q    = ~w_diff[ND+1];
  assign o_r    = o_q ? w_diff[ND:0] : w_t;
endmodule

// File: rtl/udiv_30x16.sv
// Iterative restoring divider, 30-bit by 16-bit, one bit per enabled cycle.
// Ports: i_clk, i_reset (sync, high), i_ce, bus (slave request/result).
module udiv_30x16
  import mpy_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_ce,
  udiv_30x16_if.slave  bus
);
  localparam logic [LGNN-1:0] CNT_LAST = LGNN'(NN-1);

  logic [1:0]      r_state;
  logic [LGNN-1:0] r_cnt;
  logic [ND-1:0]   r_d;
  logic [NN-1:0]   r_qsh;
  logic [ND:0]     r_r;
  logic            r_aux;
  logic            r_err;
  logic            r_busy;
  logic            r_valid;
  udiv_res_t       r_res;

  logic [ND:0]     w_nr;
  logic            w_qb;
  logic            w_unused_r;

  // A kept remainder is always below D, so its top bit is never set.
  assign w_unused_r = r_r[ND];

  udiv_step u_step (
    .i_r   (r_r[ND-1:0]),
    .i_bit (r_qsh[NN-1]),
    .i_d   (r_d),
    .o_r   (w_nr),
    .o_q   (w_qb)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_d     <= '0;
      r_qsh   <= '0;
      r_r     <= '0;
      r_aux   <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_res   <= '0;
    end else if (i_ce) begin
      r_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (bus.i_wr) begin
            r_d     <= bus.i_d;
            r_qsh   <= bus.i_n;
            r_aux   <= bus.i_aux;
            r_r     <= '0;
            r_cnt   <= CNT_LAST;
            r_err   <= (bus.i_d == '0);
            r_busy  <= 1'b1;
            r_state <= (bus.i_d == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          r_r   <= w_nr;
          r_qsh <= {r_qsh[NN-2:0], w_qb};
          if (r_cnt == '0) begin
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DONE: begin
          // Divide by zero reports all-ones quotient, zero remainder.
          r_res.q   <= r_err ? '1 : r_qsh;
          r_res.r   <= r_err ? '0 : r_r[ND-1:0];
          r_res.err <= r_err;
          r_res.aux <= r_aux;
          r_valid   <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_busy  = r_busy;
  assign bus.o_valid = r_valid;
  assign bus.o_q     = r_res.q;
  assign bus.o_r     = r_res.r;
  assign bus.o_err   = r_res.err;
  assign bus.o_aux   = r_res.aux;
endmodule

// File: tb/tb_udiv_30x16.sv
// Bench for udiv_30x16: directed cases plus random operands
// checked against plain q = n / d, r = n % d arithmetic.
module tb_udiv_30x16;
  import mpy_pkg::*;

  logic clk;
  logic rst;
  logic ce;
  bit   ce_rand;
  bit   ce_force;
  int   n_vec;
  int   n_err;

  udiv_30x16_if bus ();

  udiv_30x16 dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_ce    (ce),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // en reports whether the edge just taken was clock-enabled.
  task automatic tick(output bit en);
    en = ce;
    @(posedge clk);
    #1;
    ce = ce_rand ? 1'($urandom_range(0, 1)) : ce_force;
  endtask

  // Properties on every cycle.
  logic [1:0] p_state;
  logic       p_valid;
  always @(posedge clk) begin
    p_state <= dut.r_state;
    p_valid <= bus.o_valid;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_valid && !p_valid)
        chk("valid_from_done", 64'(p_state), 64'(S_DONE));
      if (dut.r_state == S_IDLE)
        chk("idle_not_busy", 64'(bus.o_busy), 64'd0);
      chk("cnt_range", 64'(int'(dut.r_cnt) <= NN - 1), 64'd1);
    end
  end

  task automatic run_op(input logic [NN-1:0] n,
                        input logic [ND-1:0] d,
                        input logic aux,
                        input int inj,
                        input bit post);
    bit en;
    int lat;
    int cyc;
    bit got;
    logic [NN-1:0] eq;
    logic [ND-1:0] er;
    logic ee;
    bit save_rand;
    if (d == '0) begin
      eq = '1;
      er = '0;
      ee = 1'b1;
    end else begin
      eq = n / {14'd0, d};
      er = ND'(n % {14'd0, d});
      ee = 1'b0;
    end
    bus.i_wr  = 1'b1;
    bus.i_n   = n;
    bus.i_d   = d;
    bus.i_aux = aux;
    cyc = 0;
    do begin
      tick(en);
      cyc++;
    end while (!en && cyc < 100);
    bus.i_wr = 1'b0;
    chk("busy_after_accept", 64'(bus.o_busy), 64'd1);
    lat = 0;
    got = 0;
    cyc = 0;
    while (!got && cyc < 400) begin
      if (lat == inj) begin
        bus.i_wr  = 1'b1;
        bus.i_n   = 30'd12;
        bus.i_d   = 16'd3;
        bus.i_aux = ~aux;
      end else begin
        bus.i_wr = 1'b0;
      end
      tick(en);
      if (en) lat++;
      cyc++;
      if (bus.o_valid) got = 1;
    end
    bus.i_wr = 1'b0;
    chk("valid_seen", 64'(got), 64'd1);
    // Normal: valid NN+1 enabled edges after accept.
    // Divide by zero: accept cycle then DONE cycle, valid next edge.
    chk("latency", 64'(lat), 64'((d == '0) ? 1 : NN + 1));
    chk("q", 64'(bus.o_q), 64'(eq));
    chk("r", 64'(bus.o_r), 64'(er));
    chk("err", 64'(bus.o_err), 64'(ee));
    chk("aux", 64'(bus.o_aux), 64'(aux));
    chk("busy_at_valid", 64'(bus.o_busy), 64'd0);
    if (post) begin
      save_rand = ce_rand;
      ce_rand  = 0;
      ce_force = 0;
      ce = 1'b0;
      repeat (3) tick(en);
      chk("valid_hold_ce0", 64'(bus.o_valid), 64'd1);
      ce_force = 1;
      ce = 1'b1;
      tick(en);
      chk("valid_one_cycle", 64'(bus.o_valid), 64'd0);
      chk("q_hold", 64'(bus.o_q), 64'(eq));
      chk("r_hold", 64'(bus.o_r), 64'(er));
      ce_rand = save_rand;
    end
  endtask

  initial begin
    bit en;
    int cnt;
    int vseen;
    logic [31:0] rv;
    logic [NN-1:0] rn;
    logic [ND-1:0] rd;
    int p;
    n_vec = 0;
    n_err = 0;
    ce_rand  = 0;
    ce_force = 1;
    rst = 1'b1;
    ce  = 1'b1;
    bus.i_wr  = 1'b0;
    bus.i_n   = '0;
    bus.i_d   = '0;
    bus.i_aux = 1'b0;
    repeat (2) tick(en);
    rst = 1'b0;
    chk("rst_busy", 64'(bus.o_busy), 64'd0);
    chk("rst_valid", 64'(bus.o_valid), 64'd0);
    chk("rst_q", 64'(bus.o_q), 64'd0);
    chk("rst_r", 64'(bus.o_r), 64'd0);
    chk("rst_err", 64'(bus.o_err), 64'd0);
    chk("rst_aux", 64'(bus.o_aux), 64'd0);

    run_op(30'd1000, 16'd7, 1'b1, -1, 1);
    run_op(30'h3FFFFFFF, 16'hFFFF, 1'b0, -1, 1);
    run_op(30'h3FFFFFFF, 16'd1, 1'b1, -1, 0);
    run_op(30'd5, 16'd9, 1'b0, -1, 1);
    run_op(30'd500, 16'd0, 1'b1, -1, 1);
    run_op(30'd1000, 16'd7, 1'b0, 10, 1);

    ce_rand = 1;
    run_op(30'd1000, 16'd7, 1'b1, 10, 0);
    run_op(30'd500, 16'd0, 1'b0, -1, 0);
    run_op(30'h3FFFFFFF, 16'hFFFF, 1'b1, -1, 1);
    ce_rand = 0;
    ce = 1'b1;

    // Abort a division with reset, taken while i_ce is low.
    bus.i_wr  = 1'b1;
    bus.i_n   = 30'd1000;
    bus.i_d   = 16'd7;
    bus.i_aux = 1'b1;
    tick(en);
    bus.i_wr = 1'b0;
    repeat (15) tick(en);
    ce_force = 0;
    ce  = 1'b0;
    rst = 1'b1;
    tick(en);
    rst = 1'b0;
    ce_force = 1;
    ce = 1'b1;
    chk("abort_busy", 64'(bus.o_busy), 64'd0);
    chk("abort_valid", 64'(bus.o_valid), 64'd0);
    chk("abort_q", 64'(bus.o_q), 64'd0);
    chk("abort_r", 64'(bus.o_r), 64'd0);
    chk("abort_err", 64'(bus.o_err), 64'd0);
    chk("abort_aux", 64'(bus.o_aux), 64'd0);
    vseen = 0;
    for (int i = 0; i < 60; i++) begin
      tick(en);
      if (bus.o_valid) vseen++;
    end
    chk("no_valid_after_abort", 64'(vseen), 64'd0);
    run_op(30'd1000, 16'd7, 1'b0, -1, 1);

    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      ce_rand = (i >= 800);
      rv = $urandom;
      rn = rv[NN-1:0];
      if ($urandom_range(0, 3) == 0)
        rn = rn >> $urandom_range(0, 29);
      p = int'($urandom_range(0, 99));
      if (p < 5) begin
        rd = '0;
      end else if (p < 30) begin
        rd = 16'($urandom_range(1, 255));
      end else begin
        rv = $urandom;
        rd = rv[ND-1:0];
        if (rd == '0) rd = 16'd1;
      end
      run_op(rn, rd, 1'($urandom_range(0, 1)), -1, 0);
      cnt++;
    end
    ce_rand = 0;
    ce = 1'b1;
    repeat (3) tick(en);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
